transfer_layer_mc: RTL and testbench
====================================

# transfer_layer_mc

Parametrised multi-channel transfer layer. One input FIFO feeds N_CH per-destination output FIFOs, routed by a header field in each word. It adds low/high watermark flow control, an init/config phase, overflow error detection and per-channel delivered-word counters that can be read back through a req/idx port. It sits between the link-side push interface and the N_CH consumer pop ports, and replaces the fixed 4-channel, 12-bit transfer layer.

## Interface
- DATA_W, 12, word width; the top CH_W bits are the destination channel.
- N_CH, 4, number of output channels (power of 2, ≥2); CH_W = $clog2(N_CH).
- IN_DEPTH, 8, input FIFO depth (power of 2).
- OUT_DEPTH, 4, depth of each output FIFO (power of 2); TH_W = $clog2(OUT_DEPTH)+1.
- CNT_W, 5, counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- init  in  1  one-cycle config strobe; latches thresholds.
- umbral_bajo  in  TH_W  low watermark.
- umbral_alto  in  TH_W  high watermark.
- push_in  in  1  write data_in into the input FIFO.
- data_in  in  DATA_W  input word.
- pop_out  in  N_CH  per-channel pop.
- data_out  out  N_CH*DATA_W  channel k at [k*DATA_W +: DATA_W].
- empty_out  out  N_CH  per-channel empty.
- pause  out  1  upstream must stop pushing.
- error  out  1  sticky overflow flag.
- state  out  3  FSM state.
- req  in  1  counter read request.
- idx  in  CH_W  counter select.
- counter_valid  out  1  counter_out is valid.
- counter_out  out  CNT_W  delivered-word count of channel idx.

## Operation
FSM states:
- RESET=0: entered asynchronously when reset=0. Leaves on the first clk edge with reset=1, going to INIT.
- INIT=1: holds until init=1. On init, latches umbral_bajo/umbral_alto into registers th_lo/th_hi, then goes to IDLE.
- IDLE=2: all FIFOs empty and no push.
- ACTIVE=3: any FIFO non-empty or push_in=1. Returns to IDLE when every FIFO is empty.
- ERROR=4: entered from IDLE/ACTIVE when any FIFO overflows. Sticky until reset. Dispatch stops; pops still drain.
- init=1 in IDLE or ACTIVE re-latches the thresholds without a state change.

Dispatch:
- Each cycle, the input FIFO head is moved to output FIFO ch = head[DATA_W-1 -: CH_W] when that FIFO is not full, the input FIFO is not empty, and state is IDLE or ACTIVE.
- At most one word moves per cycle. A full destination stalls the head; there is no reordering.

Flow control:
- pause sets when the input FIFO is full, or when any output FIFO occupancy ≥ th_hi.
- pause clears only when the input FIFO is not full and every output occupancy ≤ th_lo (hysteresis).
- If th_lo ≥ th_hi, pause follows the high condition alone.

Error conditions:
- push_in=1 while the input FIFO is full: word dropped, error=1.
- pop_out[k]=1 while channel k is empty: ignored, no error.

Counters:
- count[k] increments on every successful pop of channel k and wraps modulo 2^CNT_W.
- req=1 samples idx. Next cycle: counter_valid=1 and counter_out=count[idx], with the value taken at the sample edge.
- counter_valid is 0 on any cycle without a request the cycle before.

## Timing
- Reset values: data_out=0, empty_out=all 1, pause=0, error=0, state=0, counter_valid=0, counter_out=0, all counts 0, th_lo=th_hi=0.
- Push to dispatch: a word pushed at edge t is dispatched at edge t+1 at the earliest.
- Pop latency: data_out[k] is registered and shows the popped word the cycle after pop_out[k].
- Simultaneous push and dispatch on the input FIFO: both happen, occupancy unchanged.
- Simultaneous dispatch into and pop from an output FIFO: both happen. Push when full together with a pop is not an overflow.
- Pointers wrap at the FIFO depth; full/empty are derived from occupancy.
- Status timing: pause and error are registered and update one cycle after the triggering condition.
- Reset asserted mid-transfer: immediate clear; in-flight data is lost.

## Structure
- Package transfer_layer_pkg holds the state encodings and a ch_of(word) function.
- Sub-module fifo_sync (parameters WIDTH, DEPTH) with outputs full, empty and occupancy. It is instantiated once for the input and N_CH times for the outputs.
- Top level contains the FSM, dispatch, watermark logic and counters.

## Test plan
- Reset then init with umbral_alto=3, umbral_bajo=1: state goes 0→1→2, and th_hi=3, th_lo=1 are latched.
- Push 0x015 (ch0) and 0xC20 (ch3), then pop ch0 and ch3: data_out ch0=0x015 and ch3=0xC20 one cycle after each pop; state returns to 2.
- Push 3 words to ch1 with no pops: pause=1. Pop 2 words: pause=0 once occupancy ≤1.
- Push 9 words with all outputs full (dispatch stalled): the 9th word is dropped, error=1, state=4. Pops still drain the outputs.
- Pop ch2 five times, then req=1 with idx=2: counter_valid=1 and counter_out=5 on the next cycle. Pop 32 more times: counter_out=5 again (wrap).
- Assert reset mid-stream: all outputs return to their reset values asynchronously, and no data remains after reset is released.

Source files
------------

// File: rtl/transfer_layer_pkg.sv
// Shared state encodings and header decode for the multi-channel transfer layer.
package transfer_layer_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // Destination channel lives in the top ch_w bits of a data_w-bit word.
    function automatic int unsigned ch_of(input logic [63:0] word,
                                          input int unsigned data_w,
                                          input int unsigned ch_w);
        logic [63:0] sh;
        sh = (word >> (data_w - ch_w)) & ((64'd1 << ch_w) - 64'd1);
        return 32'(sh);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO; head word is visible on dout while not empty.
module fifo_sync #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      occ_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (occ_q == '0);
    assign full      = (occ_q == (AW+1)'(DEPTH));
    assign occupancy = occ_q;
    assign dout      = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so push-while-full-with-pop is legal.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + (AW+1)'(1);
                2'b01:   occ_q <= occ_q - (AW+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/transfer_layer_mc.sv
// Routes words from one input FIFO to N_CH output FIFOs by header channel,
// with watermark pause, sticky overflow error and per-channel pop counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RESET  | held in reset; leaves to ST_INIT on first clock after release
// ST_INIT   | waiting for init strobe to latch watermarks
// ST_IDLE   | configured, all FIFOs empty, no push
// ST_ACTIVE | data in flight or being pushed
// ST_ERROR  | overflow seen; dispatch frozen, pops still drain; sticky
module transfer_layer_mc
    import transfer_layer_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int N_CH      = 4,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = 5,
    localparam int CH_W     = $clog2(N_CH),
    localparam int TH_W     = $clog2(OUT_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [TH_W-1:0]          umbral_bajo,
    input  logic [TH_W-1:0]          umbral_alto,
    input  logic                     push_in,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [N_CH-1:0]          pop_out,
    output logic [N_CH*DATA_W-1:0]   data_out,
    output logic [N_CH-1:0]          empty_out,
    output logic                     pause,
    output logic                     error,
    output logic [2:0]               state,
    input  logic                     req,
    input  logic [CH_W-1:0]          idx,
    output logic                     counter_valid,
    output logic [CNT_W-1:0]         counter_out
);
    state_e              state_q, state_d;
    logic [TH_W-1:0]     th_lo_q, th_hi_q;
    logic                pause_q, pause_d;
    logic                error_q;
    logic [DATA_W-1:0]   data_out_q [N_CH];
    logic [CNT_W-1:0]    count_q [N_CH];
    logic                counter_valid_q;
    logic [CNT_W-1:0]    counter_out_q;

    logic [DATA_W-1:0]   in_head;
    logic                in_full, in_empty, in_ovf;
    logic [$clog2(IN_DEPTH):0] in_occ;
    logic                unused_in_occ;

    logic [DATA_W-1:0]   out_head [N_CH];
    logic [TH_W-1:0]     out_occ [N_CH];
    logic [N_CH-1:0]     out_full, out_empty, out_ovf, out_push, out_pop;

    logic [CH_W-1:0]     head_ch;
    logic                run_st, cfg_st, dispatch, ovf;
    logic                hi_cond, lo_cond;

    assign unused_in_occ = ^in_occ;

    assign run_st   = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign cfg_st   = run_st || (state_q == ST_ERROR);
    assign head_ch  = CH_W'(ch_of(64'(in_head), DATA_W, CH_W));
    assign dispatch = run_st && !in_empty && !out_full[head_ch];
    assign out_pop  = pop_out & ~out_empty;
    assign ovf      = in_ovf | (|out_ovf);

    fifo_sync #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_in),
        .pop       (dispatch),
        .din       (data_in),
        .dout      (in_head),
        .full      (in_full),
        .empty     (in_empty),
        .occupancy (in_occ),
        .overflow  (in_ovf)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_out
        assign out_push[k] = dispatch && (head_ch == CH_W'(k));
        assign data_out[k*DATA_W +: DATA_W] = data_out_q[k];

        fifo_sync #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (out_push[k]),
            .pop       (pop_out[k]),
            .din       (in_head),
            .dout      (out_head[k]),
            .full      (out_full[k]),
            .empty     (out_empty[k]),
            .occupancy (out_occ[k]),
            .overflow  (out_ovf[k])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT:  if (init) state_d = ST_IDLE;
            ST_IDLE, ST_ACTIVE: begin
                if (ovf)
                    state_d = ST_ERROR;
                else if (!in_empty || (out_empty != '1) || push_in)
                    state_d = ST_ACTIVE;
                else
                    state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    // Watermarks are meaningless before configuration, so only input-full pauses then.
    always_comb begin
        hi_cond = in_full;
        lo_cond = !in_full;
        for (int k = 0; k < N_CH; k++) begin
            if (out_occ[k] >= th_hi_q) hi_cond = 1'b1;
            if (out_occ[k] >  th_lo_q) lo_cond = 1'b0;
        end
        pause_d = pause_q;
        if (!cfg_st)
            pause_d = in_full;
        else if (th_lo_q >= th_hi_q)
            pause_d = hi_cond;
        else if (hi_cond)
            pause_d = 1'b1;
        else if (lo_cond)
            pause_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_RESET;
            th_lo_q         <= '0;
            th_hi_q         <= '0;
            pause_q         <= 1'b0;
            error_q         <= 1'b0;
            counter_valid_q <= 1'b0;
            counter_out_q   <= '0;
            for (int k = 0; k < N_CH; k++) begin
                data_out_q[k] <= '0;
                count_q[k]    <= '0;
            end
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
            error_q <= error_q | ovf;
            if (init && (state_q == ST_INIT || run_st)) begin
                th_lo_q <= umbral_bajo;
                th_hi_q <= umbral_alto;
            end
            counter_valid_q <= req;
            if (req) counter_out_q <= count_q[idx];
            for (int k = 0; k < N_CH; k++) begin
                if (out_pop[k]) begin
                    data_out_q[k] <= out_head[k];
                    count_q[k]    <= count_q[k] + CNT_W'(1);
                end
            end
        end
    end

    assign empty_out     = out_empty;
    assign pause         = pause_q;
    assign error         = error_q;
    assign state         = state_q;
    assign counter_valid = counter_valid_q;
    assign counter_out   = counter_out_q;

endmodule

// File: tb/tb_transfer_layer_mc.sv
// Directed bench for transfer_layer_mc: config, routing, watermarks, counters, overflow, reset.
module tb_transfer_layer_mc;
    localparam int DATA_W = 12;
    localparam int N_CH   = 4;
    localparam int CH_W   = 2;
    localparam int TH_W   = 3;
    localparam int CNT_W  = 5;

    logic                    clk;
    logic                    reset;
    logic                    init;
    logic [TH_W-1:0]         umbral_bajo, umbral_alto;
    logic                    push_in;
    logic [DATA_W-1:0]       data_in;
    logic [N_CH-1:0]         pop_out;
    logic [N_CH*DATA_W-1:0]  data_out;
    logic [N_CH-1:0]         empty_out;
    logic                    pause, error;
    logic [2:0]              state;
    logic                    req;
    logic [CH_W-1:0]         idx;
    logic                    counter_valid;
    logic [CNT_W-1:0]        counter_out;

    int n_pass = 0;
    int n_chk  = 0;

    transfer_layer_mc dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_bajo   (umbral_bajo),
        .umbral_alto   (umbral_alto),
        .push_in       (push_in),
        .data_in       (data_in),
        .pop_out       (pop_out),
        .data_out      (data_out),
        .empty_out     (empty_out),
        .pause         (pause),
        .error         (error),
        .state         (state),
        .req           (req),
        .idx           (idx),
        .counter_valid (counter_valid),
        .counter_out   (counter_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] dout_of(input int k);
        return data_out[k*DATA_W +: DATA_W];
    endfunction

    task automatic push_one(input logic [DATA_W-1:0] w);
        push_in = 1'b1;
        data_in = w;
        tick();
        push_in = 1'b0;
    endtask

    task automatic pop_one(input int ch);
        pop_out = 4'(1 << ch);
        tick();
        pop_out = '0;
    endtask

    task automatic configure();
        umbral_alto = 3'd3;
        umbral_bajo = 3'd1;
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; umbral_bajo = '0; umbral_alto = '0;
        push_in = 1'b0; data_in = '0; pop_out = '0; req = 1'b0; idx = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_empty", empty_out, 4'hF);
        check("rst_dout", data_out, 0);
        check("rst_pause", pause, 0);
        check("rst_error", error, 0);
        check("rst_cvalid", counter_valid, 0);
        check("rst_cout", counter_out, 0);

        reset = 1'b1;
        tick();
        check("to_init", state, 1);
        configure();
        check("to_idle", state, 2);
        tick();
        check("idle_hold", state, 2);
        check("idle_pause", pause, 0);

        // routing to ch0 and ch3
        push_one(12'h015);
        check("to_active", state, 3);
        push_one(12'hC20);
        tick();
        check("routed_empty", empty_out, 4'b0110);
        pop_out = 4'b1001;
        tick();
        pop_out = '0;
        check("dout_ch0", dout_of(0), 12'h015);
        check("dout_ch3", dout_of(3), 12'hC20);
        check("drained_empty", empty_out, 4'hF);
        tick();
        check("back_idle", state, 2);

        // watermark hysteresis on ch1 (th_hi=3, th_lo=1)
        push_one(12'h4A1);
        push_one(12'h4A2);
        push_one(12'h4A3);
        tick();
        check("pause_lag", pause, 0);
        tick();
        check("pause_hi", pause, 1);
        pop_one(1);
        check("dout_ch1_a", dout_of(1), 12'h4A1);
        tick();
        check("pause_hold_occ2", pause, 1);
        pop_one(1);
        check("dout_ch1_b", dout_of(1), 12'h4A2);
        tick();
        check("pause_lo", pause, 0);
        pop_one(1);
        check("dout_ch1_c", dout_of(1), 12'h4A3);
        check("ch1_empty", empty_out, 4'hF);

        // five pops of ch2 then pipelined counter reads
        push_one(12'h801);
        push_one(12'h802);
        push_one(12'h803);
        push_one(12'h804);
        tick();
        for (int i = 0; i < 4; i++) begin
            pop_one(2);
            check("dout_ch2", dout_of(2), 12'h801 + 12'(i));
        end
        push_one(12'h805);
        tick();
        pop_one(2);
        check("dout_ch2_5", dout_of(2), 12'h805);
        pop_one(3);
        check("pop_empty_noerr", error, 0);

        req = 1'b1; idx = 2'd2;
        tick();
        check("cvalid", counter_valid, 1);
        check("count_ch2", counter_out, 5);
        idx = 2'd1;
        tick();
        check("count_ch1", counter_out, 3);
        idx = 2'd3;
        tick();
        check("count_ch3", counter_out, 1);
        req = 1'b0;
        tick();
        check("cvalid_drop", counter_valid, 0);

        // 32 more pops of ch2: counter wraps to 5
        for (int i = 0; i < 32; i++) begin
            push_one(12'h800 | 12'(i));
            tick();
            pop_one(2);
            check("wrap_data", dout_of(2), 12'h800 | 12'(i));
        end
        req = 1'b1; idx = 2'd2;
        tick();
        req = 1'b0;
        check("count_wrap", counter_out, 5);
        check("cvalid_wrap", counter_valid, 1);
        tick();

        // fill ch0 output, then the input FIFO, then overflow
        for (int i = 0; i < 12; i++) push_one(12'(i));
        check("full_no_err", error, 0);
        check("full_active", state, 3);
        push_one(12'h00C);
        check("ovf_error", error, 1);
        check("ovf_state", state, 4);
        check("ovf_pause", pause, 1);
        for (int i = 0; i < 4; i++) begin
            pop_one(0);
            check("drain_ch0", dout_of(0), 12'(i));
        end
        check("no_dispatch_err", empty_out, 4'hF);
        check("err_sticky", error, 1);
        check("err_state", state, 4);

        // asynchronous reset in the middle of a cycle
        push_in = 1'b1; data_in = 12'hC55;
        #3;
        reset = 1'b0;
        #1;
        push_in = 1'b0;
        check("arst_state", state, 0);
        check("arst_error", error, 0);
        check("arst_pause", pause, 0);
        check("arst_empty", empty_out, 4'hF);
        check("arst_dout", data_out, 0);
        check("arst_cout", counter_out, 0);
        tick();
        reset = 1'b1;
        tick();
        check("rel_init", state, 1);
        configure();
        check("rel_idle", state, 2);
        tick();
        tick();
        check("rel_no_data", state, 2);
        check("rel_empty", empty_out, 4'hF);
        req = 1'b1; idx = 2'd0;
        tick();
        req = 1'b0;
        check("rel_count0", counter_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
